// File: rtl/cache_refill_ctrl.sv
// Refill controller for a set-associative cache: picks a victim way, streams the line in
// word by word over a req/ack port, then commits tag and valid for that way.
module cache_refill_ctrl #(
    parameter int WAYS   = 4,
    parameter int SETS   = 8,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32,
    localparam int WAY_W  = $clog2(WAYS),
    localparam int IDX_W  = $clog2(SETS),
    localparam int WORD_W = $clog2(WORDS),
    localparam int OFF_W  = WORD_W + 2,
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [WAYS-1:0]   valid_vec,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [IDX_W-1:0]  fill_set,
    output logic [WAYS-1:0]   fill_way,
    output logic [WORD_W-1:0] fill_word,
    output logic [31:0]       fill_data,
    output logic              data_we,
    output logic              tag_we,
    output logic [TAG_W-1:0]  fill_tag,
    output logic              valid_din,
    output logic              busy,
    output logic              done
);

    // state  | meaning
    // IDLE   | waiting for a miss
    // REQ    | mem_req high for the current word, waiting for mem_ack
    // WRITE  | data_we pulse for the word just returned
    // COMMIT | tag_we/valid_din pulse for the victim way
    // DONE   | done pulse, back to IDLE next
    typedef enum logic [2:0] {IDLE, REQ, WRITE, COMMIT, DONE} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx_q;
    logic [TAG_W-1:0]    tag_q;
    logic [ADDR_W-1:0]   base_q;
    logic [WAY_W-1:0]    way_q;
    logic                use_rr_q;
    logic [WORD_W-1:0]   word_q;
    logic [WAY_W-1:0]    rr [SETS];

    logic [IDX_W-1:0]    miss_idx;
    logic [WAY_W-1:0]    pick_way;
    logic                pick_rr;

    assign miss_idx = miss_addr[OFF_W+IDX_W-1:OFF_W];

    // Lowest invalid way wins; the round-robin pointer only matters for a full set.
    always_comb begin
        pick_way = '0;
        pick_rr  = 1'b1;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                pick_way = WAY_W'(i);
                pick_rr  = 1'b0;
            end
        end
        if (pick_rr) pick_way = rr[miss_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx_q     <= '0;
            tag_q     <= '0;
            base_q    <= '0;
            way_q     <= '0;
            use_rr_q  <= 1'b0;
            word_q    <= '0;
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            fill_set  <= '0;
            fill_way  <= '0;
            fill_word <= '0;
            fill_data <= '0;
            data_we   <= 1'b0;
            tag_we    <= 1'b0;
            fill_tag  <= '0;
            valid_din <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            data_we   <= 1'b0;
            tag_we    <= 1'b0;
            valid_din <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        idx_q    <= miss_idx;
                        tag_q    <= miss_addr[ADDR_W-1:OFF_W+IDX_W];
                        base_q   <= miss_addr & ~ADDR_W'((1 << OFF_W) - 1);
                        mem_addr <= miss_addr & ~ADDR_W'((1 << OFF_W) - 1);
                        way_q    <= pick_way;
                        use_rr_q <= pick_rr;
                        word_q   <= '0;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        fill_data <= mem_rdata;
                        fill_set  <= idx_q;
                        fill_way  <= WAYS'(1) << way_q;
                        fill_word <= word_q;
                        data_we   <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (word_q == WORD_W'(WORDS - 1)) begin
                        tag_we    <= 1'b1;
                        valid_din <= 1'b1;
                        fill_tag  <= tag_q;
                        state     <= COMMIT;
                    end else begin
                        word_q   <= word_q + WORD_W'(1);
                        mem_addr <= base_q + ((ADDR_W'(word_q) + ADDR_W'(1)) << 2);
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                COMMIT: begin
                    if (use_rr_q) rr[idx_q] <= rr[idx_q] + WAY_W'(1);
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed-plus-random bench for cache_refill_ctrl; expectations come from a line-level
// model of victim choice, addresses, data and latency.
module tb_cache_refill_ctrl;

    localparam int WAYS   = 4;
    localparam int SETS   = 8;
    localparam int WORDS  = 4;
    localparam int ADDR_W = 32;
    localparam int OFF    = 4;
    localparam int IDX    = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        miss = 1'b0;
    logic [31:0] miss_addr = '0;
    logic [3:0]  valid_vec = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [2:0]  fill_set;
    logic [3:0]  fill_way;
    logic [1:0]  fill_word;
    logic [31:0] fill_data;
    logic        data_we;
    logic        tag_we;
    logic [24:0] fill_tag;
    logic        valid_din;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int rr_m [SETS];

    cache_refill_ctrl #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .miss(miss), .miss_addr(miss_addr), .valid_vec(valid_vec),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fill_set(fill_set), .fill_way(fill_way), .fill_word(fill_word), .fill_data(fill_data),
        .data_we(data_we), .tag_we(tag_we), .fill_tag(fill_tag), .valid_din(valid_din),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_data"}, fill_data, 0);
        chk({tag, "_tag"}, 32'(fill_tag), 0);
        chk({tag, "_ctl"}, 32'({mem_req, data_we, tag_we, valid_din, busy, done,
                                fill_set, fill_way, fill_word}), 0);
    endtask

    // One complete miss. dly = extra REQ cycles before ack; busy_miss pulses a stray miss
    // in the second REQ; abort_word >= 0 pulls reset during that word's data_we cycle.
    task automatic refill(input logic [31:0] addr, input logic [3:0] vv, input int dly,
                          input bit busy_miss, input int abort_word);
        logic [31:0] base;
        logic [31:0] data [WORDS];
        int set, way, exp_lat, w, waitc, cyc;
        bit all_valid, fin;
        base = (addr >> OFF) << OFF;
        set  = int'((addr >> OFF) % SETS);
        way  = -1;
        for (int i = 0; i < WAYS; i++) if (way < 0 && !vv[i]) way = i;
        all_valid = (way < 0);
        if (all_valid) way = rr_m[set];
        for (int i = 0; i < WORDS; i++) data[i] = $urandom;
        exp_lat = 2 * WORDS + 2 + WORDS * dly;

        miss = 1'b1; miss_addr = addr; valid_vec = vv;
        @(posedge clk); #1;
        miss = 1'b0; miss_addr = $urandom; valid_vec = 4'($urandom);
        cyc = 1; w = 0; waitc = 0; fin = 0;
        while (!fin && cyc < 400) begin
            mem_ack = 1'b0; mem_rdata = $urandom; miss = 1'b0;
            if (mem_req) begin
                chk("mem_addr", mem_addr, base + 32'(4 * w));
                if (waitc == dly) begin mem_ack = 1'b1; mem_rdata = data[w]; end
                waitc++;
                if (busy_miss && w == 1 && waitc == 1) begin
                    miss = 1'b1; miss_addr = addr ^ 32'h0000_0f50; valid_vec = 4'b0000;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            if (data_we) begin
                chk("fill_word", 32'(fill_word), 32'(w));
                chk("fill_data", fill_data, data[w]);
                chk("fill_set", 32'(fill_set), 32'(set));
                chk("fill_way", 32'(fill_way), 32'(1 << way));
                if (w == abort_word) begin
                    reset = 1'b0; mem_ack = 1'b0; miss = 1'b0;
                    #1;
                    chk_zero("abort");
                    for (int s = 0; s < SETS; s++) rr_m[s] = 0;
                    @(negedge clk); reset = 1'b1;
                    @(posedge clk); #1;
                    chk("abort_no_tag_we", 32'({tag_we, busy, mem_req}), 0);
                    return;
                end
                w++; waitc = 0;
            end
            if (tag_we) begin
                chk("words_before_commit", 32'(w), WORDS);
                chk("fill_tag", 32'(fill_tag), addr >> (OFF + IDX));
                chk("valid_din", 32'(valid_din), 1);
                chk("commit_way", 32'(fill_way), 32'(1 << way));
                chk("commit_set", 32'(fill_set), 32'(set));
                if (all_valid) rr_m[set] = (rr_m[set] + 1) % WAYS;
            end
            if (done) begin
                chk("done_latency", 32'(cyc), 32'(exp_lat));
                fin = 1;
            end
            if (!fin) begin @(posedge clk); #1; cyc++; end
        end
        if (!fin) chk("refill_timeout", 0, 1);
        miss = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_done", 32'({busy, mem_req, done}), 0);
    endtask

    function automatic logic [31:0] addr_in_set(input int set);
        return ($urandom << (OFF + IDX)) | 32'(set << OFF) | 32'($urandom_range(0, 15));
    endfunction

    initial begin
        for (int s = 0; s < SETS; s++) rr_m[s] = 0;
        #12;
        chk_zero("reset");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        refill(32'h0000_1234, 4'b0000, 0, 0, -1);            // cold miss, set 3 way 0
        refill(addr_in_set(6), 4'b1011, 0, 0, -1);           // partial set -> way 2
        for (int k = 0; k < 5; k++) refill(addr_in_set(5), 4'b1111, 0, 0, -1);
        refill(addr_in_set(1), 4'b1111, 0, 0, -1);           // untouched set still at rr 0
        refill(addr_in_set(4), 4'b0110, 6, 0, -1);           // slow memory
        refill(addr_in_set(7), 4'b1111, 1, 1, -1);           // stray miss while busy
        refill(addr_in_set(2), 4'b1111, 0, 0, -1);
        refill(addr_in_set(2), 4'b1111, 0, 0, 2);            // reset during third write
        refill(addr_in_set(2), 4'b1111, 0, 0, -1);           // rr back to 0 after reset
        for (int k = 0; k < 24; k++) begin
            refill($urandom, ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
